// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - sequential WIDTH x WIDTH unsigned multiplier built on one 2x2 array multiplier

// 2x2 unsigned array multiplier: AND-gate partial products reduced by two half adders.
module mult_arry (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] P
);
    logic pp_a1b0;
    logic pp_a0b1;
    logic pp_a1b1;
    logic c1;

    assign pp_a1b0 = a[1] & b[0];
    assign pp_a0b1 = a[0] & b[1];
    assign pp_a1b1 = a[1] & b[1];
    assign c1      = pp_a1b0 & pp_a0b1;

    assign P[0] = a[0] & b[0];
    assign P[1] = pp_a1b0 ^ pp_a0b1;
    assign P[2] = pp_a1b1 ^ c1;
    assign P[3] = pp_a1b1 & c1;
endmodule

// Walks every (i, j) digit pair of the captured operands, one pair per clock,
// accumulating shifted 2x2 partial products into a 2*WIDTH-bit sum.
module mult_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int D     = WIDTH / 2;
    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(D - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;
    logic [IDX_W-1:0]   i;
    logic [IDX_W-1:0]   j;

    logic [WIDTH-1:0]   a_shift;
    logic [WIDTH-1:0]   b_shift;
    logic [1:0]         a_dig;
    logic [1:0]         b_dig;
    logic [3:0]         pp;
    logic [2*WIDTH-1:0] pp_ext;
    logic [IDX_W+1:0]   shamt;
    logic [2*WIDTH-1:0] sum;

    // Digit i of a and digit j of b feed the single array multiplier.
    assign a_shift = a_reg >> {i, 1'b0};
    assign b_shift = b_reg >> {j, 1'b0};
    assign a_dig   = a_shift[1:0];
    assign b_dig   = b_shift[1:0];

    mult_arry u_mult (
        .a (a_dig),
        .b (b_dig),
        .P (pp)
    );

    // Zero-extend the partial product, then weight it by 4^(i+j).
    always_comb begin
        pp_ext      = '0;
        pp_ext[3:0] = pp;
    end

    assign shamt = {({1'b0, i} + {1'b0, j}), 1'b0};
    assign sum   = acc + (pp_ext << shamt);

    // Outputs are pure decodes of the state register, so they change only at clock edges.
    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

    // Control FSM and datapath registers; reset overrides every other action.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            i       <= '0;
            j       <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= sum;
                    if (j == LAST) begin
                        j <= '0;
                        if (i == LAST) begin
                            i       <= '0;
                            product <= sum;
                            state   <= DONE;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - directed self-checking bench for mult_seq_ctrl at WIDTH=4 and WIDTH=8
`timescale 1ns/1ps
module tb_mult_seq_ctrl;
    logic        clk;
    logic        rst;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        busy4;
    logic        done4;
    logic [7:0]  product4;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;

    int n_checks;
    int n_fail;

    mult_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start4),
        .a_in    (a4),
        .b_in    (b4),
        .busy    (busy4),
        .done    (done4),
        .product (product4)
    );

    mult_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .start   (start8),
        .a_in    (a8),
        .b_in    (b8),
        .busy    (busy8),
        .done    (done8),
        .product (product8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge (the acceptance edge E0); returns just after E0.
    task automatic start_op4(input logic [3:0] a, input logic [3:0] b);
        start4 = 1'b1;
        a4     = a;
        b4     = b;
        tick();
        start4 = 1'b0;
    endtask

    task automatic start_op8(input logic [7:0] a, input logic [7:0] b);
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        tick();
        start8 = 1'b0;
    endtask

    // Count edges from E0 until done is seen (-1 on timeout), then step into IDLE.
    task automatic wait_done4(output int edges);
        edges = 0;
        while (done4 !== 1'b1 && edges < 50) begin
            tick();
            edges++;
        end
        if (done4 !== 1'b1) edges = -1;
        else tick();
    endtask

    task automatic wait_done8(output int edges);
        edges = 0;
        while (done8 !== 1'b1 && edges < 100) begin
            tick();
            edges++;
        end
        if (done8 !== 1'b1) edges = -1;
        else tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || product4 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_w4: busy=%b done=%b product=%0d, need 0 0 0", busy4, done4, product4);
        end
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_w8: busy=%b done=%b product=%0d, need 0 0 0", busy8, done8, product8);
        end
    endtask

    task automatic test_max_operands();
        int busy_cnt;
        int done_cnt;
        int done_at;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        start_op4(4'd15, 4'd15);
        for (int k = 0; k < 8; k++) begin
            if (busy4 === 1'b1) busy_cnt++;
            if (done4 === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (k == 2) begin
                n_checks++;
                if (product4 !== 8'd0) begin
                    n_fail++;
                    $display("FAIL max_product_during_run: product=%0d, need 0", product4);
                end
            end
            tick();
        end
        n_checks++;
        if (busy_cnt != 5) begin
            n_fail++;
            $display("FAIL max_busy_cycles: got %0d, need 5", busy_cnt);
        end
        n_checks++;
        if (done_cnt != 1 || done_at != 4) begin
            n_fail++;
            $display("FAIL max_done_pulse: count=%0d at=%0d, need 1 at 4", done_cnt, done_at);
        end
        n_checks++;
        if (product4 !== 8'hE1) begin
            n_fail++;
            $display("FAIL max_product: got %0d, need 225", product4);
        end
    endtask

    task automatic test_sequence();
        int edges;
        start_op4(4'd9, 4'd6);
        wait_done4(edges);
        n_checks++;
        if (edges != 4 || product4 !== 8'd54) begin
            n_fail++;
            $display("FAIL seq_9x6: edges=%0d product=%0d, need 4 54", edges, product4);
        end
        start_op4(4'd0, 4'd13);
        tick();
        n_checks++;
        if (product4 !== 8'd54 || busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_hold: product=%0d busy=%b, need 54 1", product4, busy4);
        end
        wait_done4(edges);
        n_checks++;
        if (edges != 3 || product4 !== 8'd0) begin
            n_fail++;
            $display("FAIL seq_0x13: edges=%0d product=%0d, need 3 0", edges, product4);
        end
    endtask

    task automatic test_start_while_busy();
        int edges;
        int extra_done;
        start_op4(4'd3, 4'd5);
        start4 = 1'b1;
        a4     = 4'd15;
        b4     = 4'd15;
        tick();
        tick();
        start4 = 1'b0;
        a4     = 4'd1;
        b4     = 4'd1;
        wait_done4(edges);
        n_checks++;
        if (edges != 2 || product4 !== 8'd15) begin
            n_fail++;
            $display("FAIL busy_ignore: edges=%0d product=%0d, need 2 15", edges, product4);
        end
        extra_done = 0;
        for (int k = 0; k < 8; k++) begin
            if (done4 === 1'b1 || busy4 === 1'b1) extra_done++;
            tick();
        end
        n_checks++;
        if (extra_done != 0) begin
            n_fail++;
            $display("FAIL busy_ignore_no_second_op: active cycles=%0d, need 0", extra_done);
        end
    endtask

    task automatic test_reset_abort();
        int edges;
        int stray;
        start_op4(4'd7, 4'd7);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || product4 !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b done=%b product=%0d, need 0 0 0", busy4, done4, product4);
        end
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            if (done4 === 1'b1) stray++;
            tick();
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: done pulses=%0d, need 0", stray);
        end
        rst    = 1'b1;
        start4 = 1'b1;
        a4     = 4'd2;
        b4     = 4'd2;
        tick();
        rst    = 1'b0;
        start4 = 1'b0;
        n_checks++;
        if (busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_beats_start: busy=%b, need 0", busy4);
        end
        start_op4(4'd2, 4'd3);
        wait_done4(edges);
        n_checks++;
        if (edges != 4 || product4 !== 8'd6) begin
            n_fail++;
            $display("FAIL after_abort_2x3: edges=%0d product=%0d, need 4 6", edges, product4);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int first_at;
        int last_at;
        int bad_prod;
        pulses   = 0;
        first_at = -1;
        last_at  = -1;
        bad_prod = 0;
        start4 = 1'b1;
        a4     = 4'd5;
        b4     = 4'd10;
        for (int k = 0; k <= 16; k++) begin
            tick();
            if (done4 === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = k;
                last_at = k;
                if (product4 !== 8'd50) bad_prod++;
            end
        end
        start4 = 1'b0;
        n_checks++;
        if (pulses != 3 || first_at != 4 || last_at != 16) begin
            n_fail++;
            $display("FAIL b2b_pulses: count=%0d first=%0d last=%0d, need 3 4 16", pulses, first_at, last_at);
        end
        n_checks++;
        if (bad_prod != 0) begin
            n_fail++;
            $display("FAIL b2b_product: %0d pulses with wrong product, need 0 (last=%0d, need 50)", bad_prod, product4);
        end
        tick();
        n_checks++;
        if (busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_release: busy=%b, need 0", busy4);
        end
    endtask

    task automatic test_width8();
        int edges;
        start_op8(8'd255, 8'd255);
        wait_done8(edges);
        n_checks++;
        if (edges != 16 || product8 !== 16'hFE01) begin
            n_fail++;
            $display("FAIL w8_255x255: edges=%0d product=%0d, need 16 65025", edges, product8);
        end
        start_op8(8'd200, 8'd3);
        wait_done8(edges);
        n_checks++;
        if (edges != 16 || product8 !== 16'd600) begin
            n_fail++;
            $display("FAIL w8_200x3: edges=%0d product=%0d, need 16 600", edges, product8);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start4   = 1'b0;
        a4       = '0;
        b4       = '0;
        start8   = 1'b0;
        a8       = '0;
        b8       = '0;
        test_reset();
        test_max_operands();
        test_sequence();
        test_start_while_busy();
        test_reset_abort();
        test_back_to_back();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
